// File: rtl/gpu_pkg.sv
// Shared types and field positions for the GPU command front end.
package gpu_pkg;

  localparam int COORD_W = 16;
  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 28;
  localparam int TEX_MSB = 7;
  localparam int TEX_LSB = 0;

  typedef enum logic [3:0] {
    OP_DRAW    = 4'd0,
    OP_DRAW_NF = 4'd1,
    OP_END     = 4'd2
  } opcode_e;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_V1,
    ST_V2,
    ST_V3,
    ST_EMIT
  } parser_state_e;

  // Bit layout matches a vertex word: x in the upper half, y in the lower.
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } vertex_t;

  typedef struct packed {
    logic          new_frame;
    logic [7:0]    texnum;
    vertex_t [2:0] v;
  } tri_desc_t;

endpackage

// File: rtl/gpu_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module gpu_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/gpu_cmd_parser.sv
// Drains the command FIFO, assembles triangle descriptors for the rasterizer
// and flags end-of-frame; malformed packets are dropped and counted.
module gpu_cmd_parser
  import gpu_pkg::*;
#(
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 320,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      fifo_rdata,
  input  logic             fifo_empty,
  output logic             fifo_read,
  output logic             tri_valid,
  input  logic             tri_ready,
  output logic             tri_new_frame,
  output logic [7:0]       tri_texnum,
  output logic [15:0]      tri_x1,
  output logic [15:0]      tri_y1,
  output logic [15:0]      tri_x2,
  output logic [15:0]      tri_y2,
  output logic [15:0]      tri_x3,
  output logic [15:0]      tri_y3,
  output logic             end_frame,
  output logic             busy,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] bad_op_cnt
);

  localparam logic [COORD_W-1:0] MAX_X = COORD_W'(SCREEN_W);
  localparam logic [COORD_W-1:0] MAX_Y = COORD_W'(SCREEN_H);

  parser_state_e state_q, state_d;
  tri_desc_t     desc_q, desc_d;
  logic          err_q, err_d;
  logic          end_q, end_d;
  logic          drop_inc, bad_op_inc;

  logic          pop;
  logic [3:0]    op;
  vertex_t       vtx;
  logic          vtx_bad;

  // Reset must not consume a word, so it masks the pop.
  assign pop     = !reset && !fifo_empty &&
                   (state_q inside {ST_HDR, ST_V1, ST_V2, ST_V3});
  assign op      = fifo_rdata[OP_MSB:OP_LSB];
  assign vtx     = vertex_t'(fifo_rdata);
  assign vtx_bad = (vtx.x >= MAX_X) || (vtx.y >= MAX_Y);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    desc_d     = desc_q;
    err_d      = err_q;
    end_d      = 1'b0;
    drop_inc   = 1'b0;
    bad_op_inc = 1'b0;
    case (state_q)
      ST_HDR: if (pop) begin
        case (op)
          OP_DRAW, OP_DRAW_NF: begin
            desc_d.new_frame = (op == OP_DRAW_NF);
            desc_d.texnum    = fifo_rdata[TEX_MSB:TEX_LSB];
            state_d          = ST_V1;
          end
          OP_END:  end_d      = 1'b1;
          default: bad_op_inc = 1'b1;
        endcase
      end
      ST_V1: if (pop) begin
        desc_d.v[0] = vtx;
        err_d       = vtx_bad;
        state_d     = ST_V2;
      end
      ST_V2: if (pop) begin
        desc_d.v[1] = vtx;
        err_d       = err_q | vtx_bad;
        state_d     = ST_V3;
      end
      ST_V3: if (pop) begin
        desc_d.v[2] = vtx;
        if (err_q || vtx_bad) begin
          drop_inc = 1'b1;
          err_d    = 1'b0;
          state_d  = ST_HDR;
        end else begin
          state_d  = ST_EMIT;
        end
      end
      ST_EMIT: if (tri_ready) state_d = ST_HDR;
      default: state_d = ST_HDR;
    endcase
  end

  // NOTE: the descriptor register is reset too, so its outputs read 0 after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_HDR;
      desc_q  <= '0;
      err_q   <= 1'b0;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      desc_q  <= desc_d;
      err_q   <= err_d;
      end_q   <= end_d;
    end
  end

  gpu_sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (drop_inc),
    .count (drop_cnt)
  );

  gpu_sat_counter #(.CNT_W(CNT_W)) u_bad_op_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (bad_op_inc),
    .count (bad_op_cnt)
  );

  assign fifo_read     = pop;
  assign tri_valid     = (state_q == ST_EMIT);
  assign busy          = (state_q != ST_HDR);
  assign end_frame     = end_q;
  assign tri_new_frame = desc_q.new_frame;
  assign tri_texnum    = desc_q.texnum;
  assign tri_x1        = desc_q.v[0].x;
  assign tri_y1        = desc_q.v[0].y;
  assign tri_x2        = desc_q.v[1].x;
  assign tri_y2        = desc_q.v[1].y;
  assign tri_x3        = desc_q.v[2].x;
  assign tri_y3        = desc_q.v[2].y;

endmodule

// File: tb/tb_gpu_cmd_parser.sv
// Scoreboard bench for gpu_cmd_parser: a packet-level model predicts
// descriptors, drops, bad opcodes and END pulses; a monitor compares.
module tb_gpu_cmd_parser;

  localparam int SW = 320;
  localparam int SH = 320;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] fifo_rdata;
  logic        fifo_empty;
  logic        fifo_read;
  logic        tri_valid;
  logic        tri_ready;
  logic        tri_new_frame;
  logic [7:0]  tri_texnum;
  logic [15:0] tri_x1, tri_y1, tri_x2, tri_y2, tri_x3, tri_y3;
  logic        end_frame;
  logic        busy;
  logic [15:0] drop_cnt, bad_op_cnt;

  gpu_cmd_parser #(.SCREEN_W(SW), .SCREEN_H(SH), .CNT_W(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .fifo_rdata    (fifo_rdata),
    .fifo_empty    (fifo_empty),
    .fifo_read     (fifo_read),
    .tri_valid     (tri_valid),
    .tri_ready     (tri_ready),
    .tri_new_frame (tri_new_frame),
    .tri_texnum    (tri_texnum),
    .tri_x1        (tri_x1),
    .tri_y1        (tri_y1),
    .tri_x2        (tri_x2),
    .tri_y2        (tri_y2),
    .tri_x3        (tri_x3),
    .tri_y3        (tri_y3),
    .end_frame     (end_frame),
    .busy          (busy),
    .drop_cnt      (drop_cnt),
    .bad_op_cnt    (bad_op_cnt)
  );

  always #5 clk = ~clk;

  // Show-ahead FIFO model: stimulus writes, the DUT pops.
  logic [31:0] mem [0:1023];
  logic [9:0]  wr_ptr = '0;
  logic [9:0]  rd_ptr = '0;
  logic        gap_en = 1'b0;
  logic        gap_phase = 1'b0;
  int          cyc = 0;

  assign fifo_empty = (rd_ptr == wr_ptr) || (gap_en && gap_phase);
  assign fifo_rdata = mem[rd_ptr];

  always @(posedge clk) begin
    if (fifo_read && !fifo_empty) rd_ptr <= rd_ptr + 10'd1;
    gap_phase <= ~gap_phase;
    cyc       <= cyc + 1;
  end

  // Scoreboard state
  logic [104:0] exp_q [$];
  int           accept_cyc [$];
  int n_checks = 0, n_errors = 0;
  int drop_exp = 0, bad_exp = 0, end_exp = 0;
  int end_seen = 0, pop_cnt = 0, valid_cycles = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    mem[wr_ptr] = w;
    wr_ptr      = wr_ptr + 10'd1;
  endtask

  // Reference model: a draw packet yields a descriptor only if all six
  // coordinates lie on screen; otherwise it counts as one drop.
  task automatic send_tri(input logic [3:0] op, input logic [7:0] tex,
                          input logic [15:0] x1, y1, x2, y2, x3, y3);
    push_word({op, 20'($urandom), tex});
    push_word({x1, y1});
    push_word({x2, y2});
    push_word({x3, y3});
    if (x1 < SW && x2 < SW && x3 < SW && y1 < SH && y2 < SH && y3 < SH)
      exp_q.push_back({op == 4'd1, tex, x1, y1, x2, y2, x3, y3});
    else
      drop_exp++;
  endtask

  // Single-word headers: END or an illegal opcode.
  task automatic send_ctl(input logic [3:0] op);
    push_word({op, 20'($urandom), 8'($urandom)});
    if (op == 4'd2) end_exp++;
    else            bad_exp++;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (!(rd_ptr == wr_ptr && !busy && exp_q.size() == 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_timeout"}, 128'(n >= budget), 128'(0));
    repeat (3) @(negedge clk);
  endtask

  function automatic logic [15:0] rand_coord();
    int k = $urandom_range(0, 31);
    case (k)
      0:       return 16'(SW);
      1:       return 16'(SW - 1);
      2:       return 16'($urandom);
      3:       return 16'd0;
      default: return 16'($urandom_range(0, SW - 1));
    endcase
  endfunction

  // Monitor: samples just after the negedge, once stimulus has settled.
  always @(negedge clk) begin
    #2;
    if (reset) begin
      if (fifo_read) check("pop_in_reset", fifo_read, 0);
    end else begin
      if (fifo_read) begin
        check("pop_nonempty", fifo_empty, 0);
        if (!fifo_empty) pop_cnt++;
      end
      if (tri_valid) begin
        valid_cycles++;
        check("no_pop_while_valid", fifo_read, 0);
        check("busy_while_valid", busy, 1);
        if (exp_q.size() == 0) begin
          check("tri_pending", 0, 1);
        end else begin
          check("tri_desc", {tri_new_frame, tri_texnum, tri_x1, tri_y1,
                             tri_x2, tri_y2, tri_x3, tri_y3}, exp_q[0]);
          if (tri_ready) begin
            accept_cyc.push_back(cyc);
            void'(exp_q.pop_front());
          end
        end
      end
      if (end_frame) end_seen++;
    end
  end

  initial begin
    int p0, v0, e0, a0, n;
    reset     = 1'b1;
    tri_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", {tri_valid, end_frame, busy, fifo_read, tri_new_frame,
                            tri_texnum, tri_x1, tri_y3, drop_cnt, bad_op_cnt}, 0);
    reset = 1'b0;

    // New-frame triangle, ready held high
    p0 = pop_cnt; v0 = valid_cycles;
    send_tri(4'd1, 8'd1, 16'd10, 16'd10, 16'd10, 16'd110, 16'd110, 16'd10);
    wait_idle(100, "t1");
    check("t1_pops", pop_cnt - p0, 4);
    check("t1_valid_cycles", valid_cycles - v0, 1);

    // Back-pressure: descriptor held, following END waits
    tri_ready = 1'b0;
    send_tri(4'd0, 8'd2, 16'd10, 16'd10, 16'd10, 16'd110, 16'd110, 16'd10);
    send_ctl(4'd2);
    n = 0;
    while (!tri_valid && n < 50) begin @(negedge clk); n++; end
    check("t2_valid_timeout", n >= 50, 0);
    repeat (10) begin
      @(negedge clk);
      check("t2_no_end_yet", end_frame, 0);
    end
    e0 = end_seen;
    tri_ready = 1'b1;
    @(negedge clk); check("t2_end_c1", end_frame, 0);
    @(negedge clk); check("t2_end_c2", end_frame, 1);
    @(negedge clk); check("t2_end_c3", end_frame, 0);
    wait_idle(50, "t2");
    check("t2_end_count", end_seen - e0, 1);

    // Range boundary on x and y
    send_tri(4'd0, 8'd3, 16'd0, 16'd0, 16'd5, 16'd5, 16'd320, 16'd7);
    send_tri(4'd0, 8'd3, 16'd0, 16'd0, 16'd5, 16'd5, 16'd319, 16'd7);
    wait_idle(100, "t3");
    check("t3_drop_x", drop_cnt, 1);
    send_tri(4'd1, 8'd4, 16'd1, 16'd320, 16'd2, 16'd2, 16'd3, 16'd3);
    send_tri(4'd1, 8'd4, 16'd1, 16'd319, 16'd2, 16'd2, 16'd3, 16'd3);
    wait_idle(100, "t3y");
    check("t3_drop_y", drop_cnt, 2);

    // Illegal opcode then a good packet
    send_ctl(4'd7);
    send_tri(4'd0, 8'd9, 16'd100, 16'd200, 16'd300, 16'd50, 16'd0, 16'd319);
    wait_idle(100, "t4");
    check("t4_bad_op", bad_op_cnt, 1);

    // Gappy FIFO gives the same descriptor
    gap_en = 1'b1;
    send_tri(4'd1, 8'd1, 16'd10, 16'd10, 16'd10, 16'd110, 16'd110, 16'd10);
    wait_idle(200, "t5");

    // Reset after V2 discards the partial packet
    push_word({4'd0, 20'd0, 8'd5});
    push_word({16'd1, 16'd1});
    push_word({16'd2, 16'd2});
    n = 0;
    while (rd_ptr != wr_ptr && n < 50) begin @(negedge clk); n++; end
    check("t5_partial_timeout", n >= 50, 0);
    repeat (2) @(negedge clk);
    check("t5_busy_mid_packet", busy, 1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    drop_exp = 0;
    bad_exp  = 0;
    @(negedge clk);
    check("t5_after_reset", {busy, tri_valid, drop_cnt, bad_op_cnt}, 0);
    gap_en = 1'b0;
    send_tri(4'd0, 8'd6, 16'd7, 16'd8, 16'd9, 16'd10, 16'd11, 16'd12);
    wait_idle(100, "t5b");

    // Five back-to-back triangles: one accept every five cycles
    a0 = accept_cyc.size();
    for (int i = 0; i < 5; i++)
      send_tri(4'd0, 8'(i), 16'($urandom_range(0, SW - 1)), 16'($urandom_range(0, SH - 1)),
               16'($urandom_range(0, SW - 1)), 16'($urandom_range(0, SH - 1)),
               16'($urandom_range(0, SW - 1)), 16'($urandom_range(0, SH - 1)));
    wait_idle(200, "t6");
    check("t6_accepts", accept_cyc.size() - a0, 5);
    for (int i = a0 + 1; i < accept_cyc.size(); i++)
      check("t6_spacing", accept_cyc[i] - accept_cyc[i-1], 5);
    e0 = end_seen;
    send_ctl(4'd2);
    wait_idle(50, "t6_end");
    check("t6_end_pulse", end_seen - e0, 1);
    check("t6_busy_idle", busy, 0);

    // Randomised mix with random back-pressure and FIFO gaps
    for (int i = 0; i < 40; i++) begin
      int r = $urandom_range(0, 9);
      if (r == 0)      send_ctl(4'd2);
      else if (r == 1) send_ctl(4'($urandom_range(3, 15)));
      else send_tri(4'($urandom_range(0, 1)), 8'($urandom),
                    rand_coord(), rand_coord(), rand_coord(),
                    rand_coord(), rand_coord(), rand_coord());
    end
    n = 0;
    while (!(rd_ptr == wr_ptr && !busy && exp_q.size() == 0) && n < 5000) begin
      tri_ready = 1'($urandom_range(0, 1));
      gap_en    = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    tri_ready = 1'b1;
    gap_en    = 1'b0;
    check("rand_timeout", n >= 5000, 0);
    repeat (3) @(negedge clk);
    check("rand_drop_cnt", drop_cnt, drop_exp);
    check("rand_bad_op_cnt", bad_op_cnt, bad_exp);
    check("rand_end_count", end_seen, end_exp);
    check("rand_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
